// File: rtl/lc3_mem_pkg.sv
// Shared encodings for the LC-3 data-memory access sequencer: operation codes,
// sequencer states and the memory-mapped I/O window base.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_LDI = 2'b10,
        OP_STI = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PTR  = 2'b01,
        ST_ACC  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [15:0] MMIO_BASE = 16'hFE00;

    // Indirect ops fetch a pointer first; bit 0 selects write for the final access.
    function automatic logic is_indirect(input op_t op);
        return op[1];
    endfunction

    function automatic logic is_write(input op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Per-access wait budget: reloads to TIMEOUT_CYC-1 on restart and counts down to 0,
// so expired rises during the TIMEOUT_CYC-th cycle spent waiting.
module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= CNT_W'(TIMEOUT_CYC - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 data-memory access sequencer: MAR/MDR capture and memory handshake for
// LD/ST/LDI/STI with per-access timeout. Optional I/O window enabled by MMIO_EN.
module mem_access_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] ea_in,
    input  logic [DATA_W-1:0] st_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
`ifdef MMIO_EN
    output logic              io_sel,
    input  logic [DATA_W-1:0] io_rdata,
`endif
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              err_q, err_d;
    logic              timer_restart;
    logic              timer_expired;
    logic              is_io;
    logic              acc_ready;
    logic [DATA_W-1:0] rd_data;

    mem_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (timer_restart),
        .expired (timer_expired)
    );

`ifdef MMIO_EN
    // I/O registers answer in the same cycle, so the final access never waits there.
    assign is_io   = (state_q == ST_ACC) && (mar_q >= DATA_W'(MMIO_BASE));
    assign io_sel  = is_io;
    assign rd_data = is_io ? io_rdata : mem_rdata;
`else
    assign is_io   = 1'b0;
    assign rd_data = mem_rdata;
`endif
    assign acc_ready = is_io || mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LD;
            mar_q   <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        mar_d         = mar_q;
        mdr_d         = mdr_q;
        err_d         = err_q;
        timer_restart = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mar_d         = ea_in;
                    mdr_d         = st_data;
                    op_d          = op_t'(op);
                    err_d         = 1'b0;
                    timer_restart = 1'b1;
                    state_d       = is_indirect(op_t'(op)) ? ST_PTR : ST_ACC;
                end
            end

            ST_PTR: begin
                mem_en = 1'b1;
                if (mem_ready) begin
                    mar_d         = mem_rdata;
                    timer_restart = 1'b1;
                    state_d       = ST_ACC;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_ACC: begin
                mem_en = !is_io;
                mem_we = is_write(op_q);
                if (acc_ready) begin
                    if (!is_write(op_q)) begin
                        mdr_d = rd_data;
                    end
                    state_d = ST_DONE;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign ld_data   = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

endmodule
